seg_scan_controller: RTL

Time-multiplexes a 4-digit common-anode seven-segment display driven by one shared segment decoder. Holds a 4-character message of 4-bit display codes: 0-9, A = '-', B = 'F', C = space. Presents one code at a time on `char` to the shared decoder and drives the matching active-low anode. Message updates are double-buffered and applied only at frame boundaries, so a frame never shows a mix of old and new characters. Inserts an all-off blanking interval before each digit to suppress ghosting.

---
 rtl/seg_scan_controller.sv | 102 ++++++++++
 1 files changed

// File: rtl/seg_scan_controller.sv
// Scan controller for a 4-digit common-anode seven-segment display sharing one decoder.
// Message writes are double-buffered and take effect only at frame boundaries.
module seg_scan_controller #(
   parameter int DIGIT_PERIOD = 50000,
   parameter int BLANK_CYCLES = 16,
   parameter int CNT_WIDTH    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        wr_en,
   input  logic [15:0] wr_data,
   output logic [3:0]  char,
   output logic [3:0]  an,
   output logic        pending,
   output logic        frame_done
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(DIGIT_PERIOD - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_BLANK  = CNT_WIDTH'(BLANK_CYCLES);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
   localparam logic [15:0]          BLANK_MSG  = 16'hCCCC;
   localparam logic [3:0]           CODE_SPACE = 4'hC;
   localparam logic [3:0]           AN_OFF     = 4'b1111;

   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] cnt_next;
   logic [1:0]           idx;
   logic [1:0]           idx_next;
   logic [15:0]          active;
   logic [15:0]          active_next;
   logic [15:0]          shadow;
   logic [15:0]          shadow_next;
   logic                 pending_next;
   logic                 slot_end;
   logic                 boundary;
   logic [3:0]           code_sel;
   logic [3:0]           an_next;
   logic [3:0]           char_next;

   // Next-state values; an/char are derived from them so the outputs stay coherent with cnt/idx.
   always_comb begin
      slot_end     = en && (cnt == CNT_LAST);
      boundary     = slot_end && (idx == 2'd3);
      cnt_next     = cnt;
      idx_next     = idx;
      active_next  = active;
      shadow_next  = shadow;
      pending_next = pending;

      if (en) begin
         cnt_next = slot_end ? '0 : cnt + CNT_ONE;
      end
      if (slot_end) begin
         idx_next = idx + 2'd1;
      end

      // A write landing on the boundary itself bypasses the shadow register.
      if (boundary) begin
         if (wr_en) begin
            active_next = wr_data;
         end else if (pending) begin
            active_next = shadow;
         end
         pending_next = 1'b0;
      end else if (wr_en) begin
         shadow_next  = wr_data;
         pending_next = 1'b1;
      end

      code_sel  = active_next[{idx_next, 2'b00} +: 4];
      an_next   = AN_OFF;
      char_next = CODE_SPACE;
      if (en && (cnt_next >= CNT_BLANK)) begin
         an_next   = ~(4'b0001 << idx_next);
         char_next = (code_sel > CODE_SPACE) ? CODE_SPACE : code_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         idx        <= 2'd0;
         active     <= BLANK_MSG;
         shadow     <= BLANK_MSG;
         pending    <= 1'b0;
         frame_done <= 1'b0;
         an         <= AN_OFF;
         char       <= CODE_SPACE;
      end else begin
         cnt        <= cnt_next;
         idx        <= idx_next;
         active     <= active_next;
         shadow     <= shadow_next;
         pending    <= pending_next;
         frame_done <= boundary;
         an         <= an_next;
         char       <= char_next;
      end
   end

endmodule
